// File: rtl/alu4_seq.sv
// Command sequencer for the 4-bit combinational ALU: 4x4 register file,
// one command in flight, IDLE -> EXEC -> DONE per command.
module alu4_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_ld,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_ra,
  input  logic [1:0] cmd_rb,
  input  logic [1:0] cmd_rd,
  input  logic [3:0] cmd_imm,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_c,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_v,
  output logic       done,
  output logic [3:0] result,
  output logic [3:0] flags,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [3:0][3:0] rf_q;
  logic            ld_q;
  logic [1:0]      rd_q;
  logic [3:0]      imm_q;
  logic [3:0]      alu_a_q, alu_b_q;
  logic [2:0]      alu_op_q;
  logic [3:0]      result_q, flags_q;
  logic            accept;
  logic [3:0]      wb_data;

  assign accept  = cmd_valid && (state_q == IDLE);
  assign wb_data = ld_q ? imm_q : alu_result;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    done      = (state_q == DONE);
  end

  // Operands are read at accept; the ALU sees them stable for the whole EXEC cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_q     <= '0;
      ld_q     <= 1'b0;
      rd_q     <= 2'd0;
      imm_q    <= 4'd0;
      alu_a_q  <= 4'd0;
      alu_b_q  <= 4'd0;
      alu_op_q <= 3'd0;
      result_q <= 4'd0;
      flags_q  <= 4'd0;
    end else begin
      if (accept) begin
        ld_q     <= cmd_ld;
        rd_q     <= cmd_rd;
        imm_q    <= cmd_imm;
        alu_a_q  <= rf_q[cmd_ra];
        alu_b_q  <= rf_q[cmd_rb];
        alu_op_q <= cmd_op;
      end
      if (state_q == EXEC) begin
        rf_q[rd_q] <= wb_data;
        result_q   <= wb_data;
        if (!ld_q) flags_q <= {alu_c, alu_n, alu_z, alu_v};
      end
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign result   = result_q;
  assign flags    = flags_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu4_seq.sv
// Bench for alu4_seq: behavioural ALU on the alu_* ports, timestamp-based
// reference model, per-cycle compare plus directed literal checks.
module tb_alu4_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_ld = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [1:0] cmd_ra = 2'd0, cmd_rb = 2'd0, cmd_rd = 2'd0;
  logic [3:0] cmd_imm = 4'd0;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_c, alu_n, alu_z, alu_v;
  logic       done;
  logic [3:0] result, flags;
  logic [1:0] dbg_addr = 2'd0;
  logic [3:0] dbg_data;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  alu4_seq dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .done(done), .result(result), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU behaviour: returns {c,n,z,v,result}
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v;
    c = 1'b0; v = 1'b0; s = 5'd0;
    case (op)
      3'd0: r = ~a;
      3'd1: r = ~b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a ^ b);
      3'd6: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[3:0]; c = s[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      default: begin
        s = {1'b0, a} + {1'b0, ~b} + 5'd1;
        r = s[3:0]; c = s[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
    endcase
    return {c, r[3], (r == 4'd0), v, r};
  endfunction

  assign {alu_c, alu_n, alu_z, alu_v, alu_result} = alu_f(alu_a, alu_b, alu_op);

  // Reference model: a command accepted at edge count m_acc writes back one
  // edge later and its done cycle follows; ready returns the cycle after.
  logic [3:0] m_rf [4];
  logic [3:0] m_a = 0, m_b = 0, m_imm = 0, m_result = 0, m_flags = 0;
  logic [2:0] m_op = 0;
  logic [1:0] m_rd = 0;
  logic       m_ld = 0, m_busy = 0;
  int         m_cyc = 0, m_acc = 0;
  logic [7:0] m_f;
  logic [3:0] m_wb;
  logic       exp_ready, exp_done;

  assign m_f       = alu_f(m_a, m_b, m_op);
  assign m_wb      = m_ld ? m_imm : m_f[3:0];
  assign exp_ready = !m_busy || (m_cyc - m_acc >= 3);
  assign exp_done  = m_busy && (m_cyc - m_acc == 2);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) m_rf[i] <= 4'd0;
      m_a <= 0; m_b <= 0; m_op <= 0; m_result <= 0; m_flags <= 0;
      m_busy <= 1'b0; m_cyc <= 0; m_acc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_busy && (m_cyc - m_acc == 1)) begin
        m_rf[m_rd] <= m_wb;
        m_result   <= m_wb;
        if (!m_ld) m_flags <= m_f[7:4];
      end
      if (exp_ready && cmd_valid) begin
        m_busy <= 1'b1; m_acc <= m_cyc;
        m_ld <= cmd_ld; m_rd <= cmd_rd; m_imm <= cmd_imm; m_op <= cmd_op;
        m_a <= m_rf[cmd_ra]; m_b <= m_rf[cmd_rb];
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", cmd_ready, exp_ready);
      chk("done", done, exp_done);
      chk("result", result, m_result);
      chk("flags", flags, m_flags);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", alu_op, m_op);
      chk("dbg_data", dbg_data, m_rf[dbg_addr]);
      chk("done_and_ready", done && cmd_ready, 0);
    end
  end

  always @(negedge clk) begin
    #1 dbg_addr = dbg_addr + 2'd1;
  end

  int acc_q[$];

  task automatic send(input logic ld, input logic [2:0] op, input logic [1:0] ra,
                      input logic [1:0] rb, input logic [1:0] rd, input logic [3:0] imm,
                      input bit keep);
    bit ok;
    ok = 1'b0;
    @(negedge clk); #1;
    cmd_ld = ld; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_imm = imm;
    cmd_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (cmd_ready) begin
        @(posedge clk); #1;
        acc_q.push_back(m_cyc);
        if (!keep) cmd_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!ok) begin
      cmd_valid = 1'b0;
      chk("accept_timeout", 0, 1);
    end
  endtask

  task automatic wait_done(output int k);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) begin k = i; break; end
    end
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  k;
    int  dones;
    bit  keep;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk_en = 1'b1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_flags", flags, 0);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      chk("rst_dbg", dbg_data, 0);
    end

    send(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd5, 1'b0); wait_done(k);
    chk("ld0_latency", k, 2);
    send(1'b1, 3'd0, 2'd0, 2'd0, 2'd1, 4'd3, 1'b0); wait_done(k);
    chk("ld1_latency", k, 2);
    chk("ld_r0", m_rf[0], 5);
    chk("ld_r1", m_rf[1], 3);
    chk("ld_flags", flags, 0);
    chk("ld_result", result, 3);

    send(1'b0, 3'b110, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0); wait_done(k);
    chk("add_latency", k, 2);
    chk("add_result", result, 8);
    chk("add_flags", flags, 4'b0101);
    chk("add_r2", m_rf[2], 8);

    send(1'b0, 3'b111, 2'd1, 2'd0, 2'd3, 4'd0, 1'b0); wait_done(k);
    chk("sub_result", result, 4'b1110);
    chk("sub_flags", flags, 4'b0100);
    chk("sub_r3", m_rf[3], 14);

    send(1'b0, 3'b100, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0); wait_done(k);
    chk("xor_result", result, 0);
    chk("xor_flags", flags, 4'b0010);
    chk("xor_r0", m_rf[0], 0);

    // back-to-back with cmd_valid held high
    acc_q.delete();
    send(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd5, 1'b1);
    send(1'b1, 3'd0, 2'd0, 2'd0, 2'd1, 4'd3, 1'b1);
    send(1'b1, 3'd0, 2'd0, 2'd0, 2'd2, 4'd8, 1'b0);
    wait_done(k);
    chk("b2b_count", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("b2b_gap1", acc_q[1] - acc_q[0], 3);
      chk("b2b_gap2", acc_q[2] - acc_q[1], 3);
    end
    chk("b2b_r2", m_rf[2], 8);

    // reset during EXEC of ADD into r2
    send(1'b0, 3'b110, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0);
    #2 reset_n = 1'b0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    #2;
    chk("rst_exec_done", dones, 0);
    chk("rst_exec_r2", m_rf[2], 0);
    chk("rst_exec_result", result, 0);
    #1 reset_n = 1'b1;
    send(1'b1, 3'd0, 2'd0, 2'd0, 2'd1, 4'd7, 1'b0); wait_done(k);
    chk("post_rst_latency", k, 2);
    chk("post_rst_result", result, 7);

    // randomized traffic; per-cycle compare checks everything
    for (int i = 0; i < 60; i++) begin
      keep = ($urandom_range(0, 2) == 0) && (i != 59);
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alu4_seq.md
# alu4_seq

Command sequencer that drives the team's 4-bit ALU from the initiator side. It owns a 4-entry × 4-bit register file and accepts one command at a time over a valid/ready handshake. For each command it either loads an immediate or issues operands and an opcode to the ALU. It then captures the ALU result and C/N/Z/V flags, writes the result back, and pulses `done`. It sits between a test/control source and the combinational ALU and closes the loop around it.

## Interface
Parameters:
- none (register count 4, data width 4, opcode width 3 are fixed)

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_ld` in 1: 1 = load immediate, 0 = ALU operation.
- `cmd_op` in 3: ALU opcode.
  - 000 ~a, 001 ~b, 010 and, 011 or, 100 xor, 101 xnor, 110 add, 111 sub.
- `cmd_ra` in 2: register index for operand a.
- `cmd_rb` in 2: register index for operand b.
- `cmd_rd` in 2: destination register index.
- `cmd_imm` in 4: immediate value for a load.
- `alu_a` out 4, `alu_b` out 4, `alu_op` out 3: registered ALU drive.
- `alu_result` in 4: ALU result, combinational from `alu_*`.
- `alu_c`, `alu_n`, `alu_z`, `alu_v` in 1 each: ALU flags.
- `done` out 1: one-cycle completion pulse.
- `result` out 4: last written value.
- `flags` out 4: {c,n,z,v} captured from the last ALU command.
- `dbg_addr` in 2 / `dbg_data` out 4: combinational register-file read port.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - EXEC: `cmd_ready`=0.
  - DONE: `cmd_ready`=0, `done`=1.
- Accept: a command is taken only when `cmd_valid`=1 in IDLE (ready is high there). Command fields are ignored at all other times.
- On the accept edge E0:
  - Latch `ld`, `rd`, `imm`.
  - `alu_a` <= reg[ra], `alu_b` <= reg[rb], `alu_op` <= `cmd_op`.
  - Go to EXEC.
  - On a load, `alu_*` are still updated but have no effect.
- On the EXEC edge E1:
  - ALU command: reg[rd] <= `alu_result`, `result` <= `alu_result`, `flags` <= {`alu_c`,`alu_n`,`alu_z`,`alu_v`}.
  - Load: reg[rd] <= imm, `result` <= imm; `flags` unchanged.
  - Go to DONE.
- On the DONE edge E2: go to IDLE.
- Operand reads use register contents at E0.
  - ra, rb and rd may alias freely.
  - Only one command is in flight, so no hazard exists.
- `alu_a`, `alu_b`, `alu_op` hold their values after E1 until the next accept.
- `dbg_data` = reg[`dbg_addr`]; it reflects a write in the cycle after the write edge.
- Reset (asynchronous, any state):
  - State to IDLE.
  - All registers, `alu_a`/`alu_b`/`alu_op`, `result`, `flags` = 0.
  - `done` = 0, `cmd_ready` = 1 while in IDLE.
  - An in-flight command is abandoned with no write-back.
- Arithmetic is entirely inside the ALU; this block never modifies result or flag values.

## Timing
- Latency: `done` is high for exactly the one cycle after E1. The written value is visible on `result`/`dbg_data` in that same cycle.
- `cmd_ready` is low from E0 until E2, and high again in the cycle after the `done` cycle.
- Throughput: one command per 3 cycles when `cmd_valid` is held high.
- `cmd_valid` held high during EXEC/DONE is not accepted until IDLE. The initiator keeps it asserted; the block takes the command at the first IDLE edge.
- ALU inputs are stable for the whole EXEC cycle. The ALU combinational path must close within one clock.
- `done` and `cmd_ready` are never high in the same cycle.

## Test plan
The bench connects the team's 4-bit ALU to the `alu_*` ports.
- Reset, then release: `cmd_ready`=1, `done`=0, `flags`=0000, `dbg_data`=0 for all four registers.
- LD r0=5; LD r1=3:
  - `done` pulses 2 cycles after each accept.
  - `dbg_data` shows r0=5, r1=3.
  - `flags` stays 0000.
- ADD (110) ra=r0, rb=r1, rd=r2 → `result`=8, `flags`={c0,n1,z0,v1}, r2=8.
- SUB (111) ra=r1, rb=r0, rd=r3 → `result`=4'b1110, `flags`={c0,n1,z0,v0}; then XOR ra=rb=rd=r0 → r0=0, `z`=1.
- Back-to-back: `cmd_valid` held high for 3 commands → accepts exactly 3 cycles apart; no command is accepted while `cmd_ready`=0.
- Reset asserted during EXEC of ADD into r2 (r2=8 beforehand):
  - r2 cleared to 0 by reset; no `done` pulse.
  - Next command completes normally.
